// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache block-fill controller: state encoding,
// default block geometry and the word-address helper.
package cache_fill_fsm_pkg;

    localparam int unsigned WORDS_PER_BLOCK_DEF = 8;
    localparam int unsigned OFFSET_BITS_DEF     = 4;
    localparam int unsigned CNT_W               = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_TAG  = 2'd2
    } fill_state_e;

    // Words are 16 bits wide, so word index i sits at byte offset 2*i.
    function automatic logic [15:0] word_addr(input logic [15:0] base,
                                              input logic [CNT_W-1:0] idx);
        return base + 16'({idx, 1'b0});
    endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for a block fill: counts up to LAST, then holds and raises a
// sticky done flag on the enable that consumes the final index.
module fill_counter
    import cache_fill_fsm_pkg::*;
#(
    parameter logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_BLOCK_DEF - 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic             done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (en_i && !done_q) begin
            if (cnt_q == LAST) begin
                done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = done_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss block-fill controller: issues one read per block word, writes
// returning words into the data array in order, then writes the tag once.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int unsigned WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
    parameter int unsigned OFFSET_BITS     = OFFSET_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic [15:0] memory_data,
    input  logic        memory_data_valid,
    output logic        fsm_busy,
    output logic        memory_read,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic        write_tag_array,
    output logic [15:0] fill_address,
    output logic [15:0] fill_data
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [15:0]      OFF_MASK = 16'((32'd1 << OFFSET_BITS) - 32'd1);

    fill_state_e      state_q;
    logic [15:0]      base_q;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] recv_cnt;
    logic             issue_done;
    logic             recv_done;
    logic             in_fill;
    logic             issue_en;
    logic             recv_en;
    logic             recv_last;

    assign in_fill   = (state_q == ST_FILL);
    assign issue_en  = in_fill && !issue_done;
    assign recv_en   = in_fill && memory_data_valid && !recv_done;
    assign recv_last = recv_en && (recv_cnt == LAST_IDX);

    fill_counter #(.LAST(LAST_IDX)) u_issue_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (!in_fill),
        .en_i   (issue_en),
        .cnt_o  (issue_cnt),
        .done_o (issue_done)
    );

    fill_counter #(.LAST(LAST_IDX)) u_recv_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (!in_fill),
        .en_i   (recv_en),
        .cnt_o  (recv_cnt),
        .done_o (recv_done)
    );

    // Miss and address are only looked at in IDLE, so later changes cannot disturb a fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss_detected) begin
                        base_q  <= miss_address & ~OFF_MASK;
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (recv_last) begin
                        state_q <= ST_TAG;
                    end
                end
                ST_TAG:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fsm_busy         = (state_q != ST_IDLE);
    assign memory_read      = issue_en;
    assign memory_address   = issue_en ? word_addr(base_q, issue_cnt) : '0;
    assign write_data_array = recv_en;
    assign write_tag_array  = (state_q == ST_TAG);
    assign fill_data        = memory_data;

    always_comb begin
        fill_address = '0;
        if (state_q == ST_TAG) begin
            fill_address = base_q;
        end else if (in_fill) begin
            fill_address = word_addr(base_q, recv_cnt);
        end
    end

endmodule
